// File: rtl/rx.sv
// Framed serial receiver: 2-flop synchronized input, start/data/stop sampling at bit centre.
// Optional RX_MAJORITY_VOTE_EN: each sample is the 2-of-3 vote of the last three synchronized values.
module rx #(
   parameter int DIVISOR    = 6771,
   parameter int DATA_LNGTH = 162
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  data_in,
   output logic [DATA_LNGTH-1:0] val_out,
   output logic                  valid_out,
   output logic                  frame_err_out,
   output logic                  busy_out
);

   localparam int CW = $clog2(DIVISOR);
   localparam int IW = $clog2(DATA_LNGTH + 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(DIVISOR / 2 - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DIVISOR - 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_LNGTH - 1);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   logic                  s1_r, s2_r, s3_r;
   logic                  sample_s;
   state_t                state_r, state_s;
   logic [CW-1:0]         cnt_r, cnt_s;
   logic [IW-1:0]         idx_r, idx_s;
   logic [DATA_LNGTH-1:0] shift_r, shift_s;
   logic [DATA_LNGTH-1:0] val_s;
   logic                  valid_s, err_s;

   // input synchronizer plus previous-sample flop for edge detection
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         s1_r <= 1'b1;
         s2_r <= 1'b1;
         s3_r <= 1'b1;
      end else begin
         s1_r <= data_in;
         s2_r <= s1_r;
         s3_r <= s2_r;
      end
   end

`ifdef RX_MAJORITY_VOTE_EN
   logic s4_r;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // s2, s3, s4 hold the synchronized line at counter values 0, 1 and 2
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         s4_r <= 1'b1;
      end else begin
         s4_r <= s3_r;
      end
   end

   assign sample_s = maj3(s2_r, s3_r, s4_r);
`else
   assign sample_s = s2_r;
`endif

   // next-state, counter, shift register and strobe decode
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      idx_s   = idx_r;
      shift_s = shift_r;
      val_s   = val_out;
      valid_s = 1'b0;
      err_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (s3_r && !s2_r) begin
               state_s = START;
               cnt_s   = CNT_HALF;
            end else begin
               state_s = IDLE;
            end
         end
         START: begin
            if (cnt_r != CNT_ZERO) begin
               cnt_s = cnt_r - CNT_ONE;
            end else if (!sample_s) begin
               state_s = DATA;
               cnt_s   = CNT_FULL;
               idx_s   = {IW{1'b0}};
            end else begin
               state_s = IDLE;
            end
         end
         DATA: begin
            if (cnt_r != CNT_ZERO) begin
               cnt_s = cnt_r - CNT_ONE;
            end else begin
               shift_s = {sample_s, shift_r[DATA_LNGTH-1:1]};
               idx_s   = idx_r + IDX_ONE;
               cnt_s   = CNT_FULL;
               state_s = (idx_r == IDX_LAST) ? STOP : DATA;
            end
         end
         STOP: begin
            if (cnt_r != CNT_ZERO) begin
               cnt_s = cnt_r - CNT_ONE;
            end else begin
               // leave at mid-stop-bit so a back-to-back start edge is not missed
               state_s = IDLE;
               if (sample_s) begin
                  val_s   = shift_r;
                  valid_s = 1'b1;
               end else begin
                  err_s = 1'b1;
               end
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // state, datapath and registered outputs
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_r       <= IDLE;
         cnt_r         <= CNT_ZERO;
         idx_r         <= {IW{1'b0}};
         shift_r       <= {DATA_LNGTH{1'b0}};
         val_out       <= {DATA_LNGTH{1'b0}};
         valid_out     <= 1'b0;
         frame_err_out <= 1'b0;
         busy_out      <= 1'b0;
      end else begin
         state_r       <= state_s;
         cnt_r         <= cnt_s;
         idx_r         <= idx_s;
         shift_r       <= shift_s;
         val_out       <= val_s;
         valid_out     <= valid_s;
         frame_err_out <= err_s;
         busy_out      <= (state_s != IDLE);
      end
   end

endmodule

// File: doc/rx.md
# rx

Serial receiver for the framed 162-bit link: samples an asynchronous single-wire input, detects a start bit, and shifts in `DATA_LNGTH` data bits LSB-first. It then checks the stop bit and presents the word in parallel with a one-cycle valid strobe. The frame is 1 start bit (0), `DATA_LNGTH` data bits with bit 0 first, and 1 stop bit (1), each `DIVISOR` clocks long; line idle is 1. The block sits at the receiving end of the link, opposite the frame transmitter, on the same clock frequency.

## Interface
- `DIVISOR`, 6771: clocks per bit; must be ≥ 8.
- `DATA_LNGTH`, 162: data bits per frame.
- `clk_in` input 1: system clock; all logic on rising edge.
- `rst_in` input 1: reset; one clock, reset is asynchronous and active-high.
- `data_in` input 1: serial line, asynchronous to `clk_in`.
- `val_out` output `DATA_LNGTH`: last good received word; `val_out[0]` is the first data bit on the wire.
- `valid_out` output 1: one-cycle pulse when `val_out` updates.
- `frame_err_out` output 1: one-cycle pulse when the stop bit samples 0.
- `busy_out` output 1: high while a frame is in progress (state ≠ IDLE).

## Operation
- Input path: 2-flop synchronizer `s1`→`s2`, plus a previous-sample flop `s3`. All three reset to 1.
- `H` = `DIVISOR/2`, using integer division. The bit counter counts down; a sample is taken when the counter is 0.
- States and transitions:
  - IDLE: waits for `s3`=1 and `s2`=0, i.e. a falling edge. Then counter ← `H`−1 and state → START.
  - START: at counter 0, sample. Sample 0 → DATA with counter ← `DIVISOR`−1 and bit index ← 0. Sample 1 → IDLE, treated as a glitch with no outputs.
  - DATA: at counter 0, sample. Shift the bit into the MSB of a `DATA_LNGTH`-bit right-shift register. Increment the index and reload the counter with `DIVISOR`−1. After `DATA_LNGTH` samples → STOP.
  - STOP: at counter 0, sample.
    - Sample 1: `val_out` ← shift register and `valid_out` pulses.
    - Sample 0: `frame_err_out` pulses and `val_out` holds its previous value.
    - Either way → IDLE.
- Leaving STOP at mid-stop-bit lets back-to-back frames be caught. IDLE re-arms only on a 1→0 edge, so a line held low (break) never retriggers until it returns high.
- `valid_out` and `frame_err_out` are never high together.
- Bit index width is `$clog2(DATA_LNGTH+1)`. Counter width is `$clog2(DIVISOR)`.

## Timing
- Reset values: `val_out`=0, `valid_out`=0, `frame_err_out`=0, `busy_out`=0, state IDLE, synchronizer flops 1.
- Reset mid-frame aborts immediately and discards the partial word. Operation resumes on the next falling edge after reset is released.
- Let `t0` be the cycle IDLE sees the edge, which is 2 clocks after `data_in` falls.
  - `busy_out` is high from `t0`+1.
  - Start-bit sample is at `t0`+`H`.
  - Data bit i is sampled at `t0`+`H`+(i+1)·`DIVISOR`.
  - Stop bit is sampled at `t0`+`H`+(`DATA_LNGTH`+1)·`DIVISOR`.
- `valid_out` or `frame_err_out` is high for exactly the one cycle after the stop sample. `busy_out` falls in that same cycle.
- Glitch rejected at START: `busy_out` is high for `H` cycles, with no strobe.

## Configuration
- `RX_MAJORITY_VOTE_EN` defined:
  - Every sample (start, data, stop) is the 2-of-3 majority of `s2` at counter values 2, 1 and 0.
  - The decision is still made at counter 0, so timing is unchanged.
- Not defined: the sample is `s2` at counter 0 only.

## Test plan
1. Frame with `DIVISOR`=16 carrying 162'h2AAAA…AAAA (alternating, bit0=0), sent from the frame transmitter → one `valid_out` pulse; `val_out` equals the sent word; `frame_err_out` stays 0.
2. `data_in` low for 3 cycles, then high → `busy_out` is high for 8 cycles, then 0; no `valid_out`; `val_out` unchanged.
3. Good frame 162'h1, then a frame of 162'h3 with the stop bit forced 0 and the line held low for 40 cycles → `frame_err_out` pulses once; `val_out` stays 162'h1; no restart until the line goes high.
4. Two frames back-to-back with no idle gap, values 162'h5 then 162'hF0 → two `valid_out` pulses, spaced 164·16 cycles apart, with `val_out` 162'h5 then 162'hF0.
5. `rst_in` pulsed during data bit 80, then a full frame of 162'h123 → all outputs read 0 immediately during reset; no strobe for the aborted frame; next frame yields `val_out`=162'h123.
6. Frame 162'h0 with a single-cycle high glitch at the mid-point of data bit 7 → with `RX_MAJORITY_VOTE_EN`, `val_out`=162'h0; without it, `val_out`=162'h80.
